// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: filtered device clock, 11-bit frame capture, E0/F0/E1 prefix decode.
// Optional PS2_PARITY_CHECK_EN rejects frames with bad odd parity; by default parity is ignored.
`timescale 1ns/1ps
module ps2_key_rx #(
    parameter int FILT_LEN = 8,
    parameter int TIMEOUT  = 24000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_dat_in,
    output logic [10:0] ps2_key,
    output logic        frame_err
);
    // state   | meaning
    // IDLE    | no prefix pending
    // EXT     | E0 seen, next code is extended
    // REL     | F0 seen, next code is a release
    // EXT_REL | E0 F0 seen, next code is an extended release
    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_REL, ST_EXT_REL} state_t;

    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_clk_filt;
    logic [FW-1:0] r_filt_cnt;
    logic [TW-1:0] r_to_cnt;
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_frame_err, r_byte_valid;
    logic [2:0]    r_pause;
    logic [10:0]   r_key;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    w_pause_nxt;
    logic          w_fall, w_par_bad, w_emit, w_ext, w_rel;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk_in;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_dat_in;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Down-counter reloads whenever the input agrees with the filtered level.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_filt <= 1'b1;
            r_filt_cnt <= FW'(FILT_LEN - 1);
        end else if (r_clk_s2 == r_clk_filt) begin
            r_filt_cnt <= FW'(FILT_LEN - 1);
        end else if (r_filt_cnt == '0) begin
            r_clk_filt <= r_clk_s2;
            r_filt_cnt <= FW'(FILT_LEN - 1);
        end else begin
            r_filt_cnt <= r_filt_cnt - 1'b1;
        end
    end

    assign w_fall = r_clk_filt & ~r_clk_s2 & (r_filt_cnt == '0);

`ifdef PS2_PARITY_CHECK_EN
    logic r_par;
    assign w_par_bad = ~(^{r_shift, r_par});
`else
    assign w_par_bad = 1'b0;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_to_cnt     <= TW'(TIMEOUT - 1);
            r_frame_err  <= 1'b0;
            r_byte_valid <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            r_par        <= 1'b0;
`endif
        end else begin
            r_frame_err  <= 1'b0;
            r_byte_valid <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= TW'(TIMEOUT - 1);
                if (r_bit_cnt == 4'd0) begin
                    if (r_dat_s2) r_frame_err <= 1'b1;
                    else          r_bit_cnt   <= 4'd1;
                end else if (r_bit_cnt <= 4'd8) begin
                    r_shift   <= {r_dat_s2, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end else if (r_bit_cnt == 4'd9) begin
`ifdef PS2_PARITY_CHECK_EN
                    r_par <= r_dat_s2;
`endif
                    r_bit_cnt <= 4'd10;
                end else begin
                    r_bit_cnt <= 4'd0;
                    if (!r_dat_s2 || w_par_bad) r_frame_err  <= 1'b1;
                    else                        r_byte_valid <= 1'b1;
                end
            end else if (r_bit_cnt != 4'd0) begin
                if (r_to_cnt == '0) begin
                    r_frame_err <= 1'b1;
                    r_bit_cnt   <= 4'd0;
                end else begin
                    r_to_cnt <= r_to_cnt - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_pause <= '0;
            r_key   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pause <= w_pause_nxt;
            if (w_emit) r_key <= {~r_key[10], ~w_rel, w_ext, r_shift};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pause_nxt = r_pause;
        w_emit      = 1'b0;
        w_ext       = 1'b0;
        w_rel       = 1'b0;
        if (r_frame_err) begin
            w_state_nxt = ST_IDLE;
            w_pause_nxt = '0;
        end else if (r_byte_valid) begin
            if (r_pause != 3'd0) begin
                w_pause_nxt = r_pause - 3'd1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_shift == 8'hE0)      w_state_nxt = ST_EXT;
                        else if (r_shift == 8'hF0) w_state_nxt = ST_REL;
                        else if (r_shift == 8'hE1) w_pause_nxt = 3'd7;
                        else                       w_emit      = 1'b1;
                    end
                    ST_EXT: begin
                        if (r_shift == 8'hF0)      w_state_nxt = ST_EXT_REL;
                        else if (r_shift != 8'hE0) begin
                            w_emit = 1'b1;
                            w_ext  = 1'b1;
                        end
                    end
                    ST_REL: begin
                        if (r_shift != 8'hF0 && r_shift != 8'hE0) begin
                            w_emit = 1'b1;
                            w_rel  = 1'b1;
                        end
                    end
                    default: begin
                        if (r_shift != 8'hF0 && r_shift != 8'hE0) begin
                            w_emit = 1'b1;
                            w_ext  = 1'b1;
                            w_rel  = 1'b1;
                        end
                    end
                endcase
                if (w_emit) w_state_nxt = ST_IDLE;
            end
        end
    end

    assign ps2_key   = r_key;
    assign frame_err = r_frame_err;
endmodule

// File: tb/tb_ps2_key_rx.sv
// Scoreboard bench for ps2_key_rx: expected key words are queued as frames are driven and
// popped whenever ps2_key changes; frame_err pulses are counted per scenario.
`timescale 1ns/1ps
module tb_ps2_key_rx;
    localparam int HP = 20;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk_in = 1'b1;
    logic        ps2_dat_in = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          err_cnt = 0;
    int          base;
    logic [10:0] q[$];
    logic        tog = 1'b0;
    logic [10:0] prev_key = '0;
    logic        prev_err = 1'b0;

    always #5 clk_sys = ~clk_sys;

    ps2_key_rx dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_key    (ps2_key),
        .frame_err  (frame_err)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
    endtask

    task automatic ps2_bit(input logic d);
        ps2_dat_in = d;
        cyc(HP);
        ps2_clk_in = 1'b0;
        cyc(HP);
        ps2_clk_in = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input int nbits = 11,
                        input logic par_flip = 1'b0, input logic stop = 1'b1);
        logic [10:0] f;
        f = {stop, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        ps2_dat_in = 1'b1;
        cyc(HP);
    endtask

    task automatic push(input logic rel, input logic ext, input logic [7:0] b);
        tog = ~tog;
        q.push_back({tog, ~rel, ext, b});
    endtask

    task automatic flush(input string tag);
        int k;
        k = 0;
        while (q.size() != 0 && k < 200) begin
            cyc(1);
            k++;
        end
        chk(tag, q.size(), 0);
    endtask

    initial begin
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                prev_key = ps2_key;
                prev_err = 1'b0;
            end else begin
                if (frame_err) begin
                    err_cnt++;
                    chk("ferr_width", int'(prev_err), 0);
                end
                prev_err = frame_err;
                if (ps2_key !== prev_key) begin
                    chk("evt_expected", (q.size() > 0) ? 1 : 0, 1);
                    if (q.size() > 0) chk("key", int'(ps2_key), int'(q.pop_front()));
                    prev_key = ps2_key;
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(5);
        chk("rst_key", int'(ps2_key), 0);
        chk("rst_ferr", int'(frame_err), 0);
        reset_n = 1'b1;
        cyc(20);

        // plain make code plus a typematic repeat
        base = err_cnt;
        push(1'b0, 1'b0, 8'h1C); send(8'h1C);
        flush("t1_key");
        push(1'b0, 1'b0, 8'h1C); send(8'h1C);
        flush("t1_repeat");
        chk("t1_ferr", err_cnt - base, 0);

        // extended make, then extended break
        push(1'b0, 1'b1, 8'h75);
        send(8'hE0); send(8'h75);
        flush("t2_ext");
        push(1'b1, 1'b1, 8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        flush("t3_ext_rel");

        // pause sequence is swallowed entirely
        base = err_cnt;
        push(1'b0, 1'b0, 8'h29);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h29);
        flush("t4_pause");
        chk("t4_ferr", err_cnt - base, 0);

        // bad parity
        base = err_cnt;
`ifdef PS2_PARITY_CHECK_EN
        send(8'h1C, 11, 1'b1);
        chk("t5_par_ferr", err_cnt - base, 1);
`else
        push(1'b0, 1'b0, 8'h1C);
        send(8'h1C, 11, 1'b1);
        chk("t5_par_ferr", err_cnt - base, 0);
`endif
        flush("t5_par");

        // partial frame then timeout, then recovery
        base = err_cnt;
        send(8'h1C, 5);
        cyc(24050);
        chk("t6_timeout_ferr", err_cnt - base, 1);
        push(1'b0, 1'b0, 8'h1C); send(8'h1C);
        flush("t6_recover");

        // short clock glitches are filtered out
        base = err_cnt;
        for (int i = 0; i < 4; i++) begin
            ps2_clk_in = 1'b0; cyc(3);
            ps2_clk_in = 1'b1; cyc(30);
        end
        push(1'b0, 1'b0, 8'h1C); send(8'h1C);
        flush("t7_glitch");
        chk("t7_ferr", err_cnt - base, 0);

        // start bit sampled high
        base = err_cnt;
        ps2_bit(1'b1); cyc(HP);
        chk("t8_start_ferr", err_cnt - base, 1);
        push(1'b0, 1'b0, 8'h5A); send(8'h5A);
        flush("t8_recover");

        // stop bit sampled low discards the byte
        base = err_cnt;
        send(8'h1C, 11, 1'b0, 1'b0);
        chk("t9_stop_ferr", err_cnt - base, 1);
        flush("t9_none");

        // frame error clears a pending E0 prefix
        base = err_cnt;
        push(1'b0, 1'b0, 8'h75);
        send(8'hE0); send(8'h33, 11, 1'b0, 1'b0); send(8'h75);
        flush("t10_prefix_clr");
        chk("t10_ferr", err_cnt - base, 1);

        // reset in the middle of a frame
        send(8'h1C, 5);
        cyc(1);
        reset_n = 1'b0;
        cyc(3);
        chk("t11_rst_key", int'(ps2_key), 0);
        tog = 1'b0;
        reset_n = 1'b1;
        cyc(20);
        base = err_cnt;
        push(1'b0, 1'b0, 8'h1C); send(8'h1C);
        flush("t11_after_rst");
        chk("t11_ferr", err_cnt - base, 0);

        cyc(50);
        chk("q_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
